// File: rtl/pma_region_checker_pkg.sv
// Shared types and constants for the runtime-programmable PMA region checker.
package pma_pkg;

   localparam int unsigned MaxRegions = 16;
   localparam int unsigned LockBit    = 7;

   typedef struct packed {
      logic ni;
      logic c;
      logic x;
   } pma_attr_t;

   typedef enum logic [1:0] {
      FIELD_BASE   = 2'd0,
      FIELD_LENGTH = 2'd1,
      FIELD_ATTR   = 2'd2,
      FIELD_RSVD   = 2'd3
   } pma_field_e;

endpackage

// File: rtl/pma_region_match.sv
// Combinational single-region compare: base <= addr < base + length, length 0 disables.
module pma_region_match
   import pma_pkg::*;
#(
   parameter int unsigned AddrWidth = 64
) (
   input  logic [AddrWidth-1:0] base_i,
   input  logic [AddrWidth-1:0] length_i,
   input  logic [AddrWidth-1:0] addr_i,
   output logic                 match_o
);

   // One extra bit on the limit so a region reaching past the top of memory never wraps.
   logic [AddrWidth:0] limit;

   assign limit   = {1'b0, base_i} + {1'b0, length_i};
   assign match_o = (length_i != '0) && (addr_i >= base_i) && ({1'b0, addr_i} < limit);

endmodule

// File: rtl/pma_region_checker.sv
// PMA checker: programmable/lockable region table, config register port and a
// pipelined lookup returning the attributes of the lowest-index matching region.
module pma_region_checker
   import pma_pkg::*;
#(
   parameter int unsigned                          NrRegions   = 4,
   parameter int unsigned                          AddrWidth   = 64,
   parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase     = '0,
   parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLength   = '0,
   parameter logic [NrRegions-1:0][2:0]           RstAttr     = '0,
   parameter logic [2:0]                          DefaultAttr = 3'b000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 cfg_req_i,
   input  logic                 cfg_we_i,
   input  logic [3:0]           cfg_idx_i,
   input  logic [1:0]           cfg_field_i,
   input  logic [AddrWidth-1:0] cfg_wdata_i,
   output logic                 cfg_gnt_o,
   output logic                 cfg_rvalid_o,
   output logic [AddrWidth-1:0] cfg_rdata_o,
   output logic                 cfg_err_o,
   input  logic                 chk_valid_i,
   output logic                 chk_ready_o,
   input  logic [AddrWidth-1:0] chk_addr_i,
   output logic                 chk_valid_o,
   input  logic                 chk_ready_i,
   output logic                 chk_hit_o,
   output logic [3:0]           chk_region_o,
   output logic [2:0]           chk_attr_o
);

   logic [NrRegions-1:0][AddrWidth-1:0] base_q, base_d, length_q, length_d;
   pma_attr_t [NrRegions-1:0]           attr_q, attr_d;
   logic [NrRegions-1:0]                lock_q, lock_d;

   logic                 cfg_rvalid_q, cfg_rvalid_d, cfg_err_q, cfg_err_d;
   logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;

   logic       chk_valid_q, chk_valid_d, chk_hit_q, chk_hit_d;
   logic [3:0] chk_region_q, chk_region_d;
   pma_attr_t  chk_attr_q, chk_attr_d;

   logic [NrRegions-1:0] match;
   logic                 idx_ok, sel_lock, accept;
   logic [AddrWidth-1:0] sel_base, sel_length;
   pma_attr_t            sel_attr;
   pma_field_e           field;

   for (genvar g = 0; g < NrRegions; g++) begin : gen_match
      pma_region_match #(.AddrWidth(AddrWidth)) u_match (
         .base_i   (base_q[g]),
         .length_i (length_q[g]),
         .addr_i   (chk_addr_i),
         .match_o  (match[g])
      );
   end

   always_comb begin
      field      = pma_field_e'(cfg_field_i);
      idx_ok     = ({1'b0, cfg_idx_i} < 5'(NrRegions));
      sel_lock   = 1'b0;
      sel_base   = '0;
      sel_length = '0;
      sel_attr   = '0;
      for (int i = 0; i < NrRegions; i++) begin
         if (cfg_idx_i == 4'(i)) begin
            sel_lock   = lock_q[i];
            sel_base   = base_q[i];
            sel_length = length_q[i];
            sel_attr   = attr_q[i];
         end
      end

      cfg_rvalid_d = cfg_req_i;
      cfg_err_d    = cfg_req_i && (!idx_ok || (field == FIELD_RSVD) || (cfg_we_i && sel_lock));
      cfg_rdata_d  = '0;
      if (cfg_req_i && !cfg_we_i && !cfg_err_d) begin
         case (field)
            FIELD_BASE:   cfg_rdata_d = sel_base;
            FIELD_LENGTH: cfg_rdata_d = sel_length;
            FIELD_ATTR: begin
               cfg_rdata_d[LockBit] = sel_lock;
               cfg_rdata_d[2:0]     = sel_attr;
            end
            default: ;
         endcase
      end

      // Writes land at the edge, so a lookup in the same cycle still sees the old table.
      base_d   = base_q;
      length_d = length_q;
      attr_d   = attr_q;
      lock_d   = lock_q;
      if (cfg_req_i && cfg_we_i && !cfg_err_d) begin
         for (int i = 0; i < NrRegions; i++) begin
            if (cfg_idx_i == 4'(i)) begin
               case (field)
                  FIELD_BASE:   base_d[i]   = cfg_wdata_i;
                  FIELD_LENGTH: length_d[i] = cfg_wdata_i;
                  FIELD_ATTR: begin
                     attr_d[i] = cfg_wdata_i[2:0];
                     lock_d[i] = cfg_wdata_i[LockBit];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign chk_ready_o = !chk_valid_q || chk_ready_i;
   assign accept      = chk_valid_i && chk_ready_o;

   always_comb begin
      chk_valid_d  = chk_valid_q;
      chk_hit_d    = chk_hit_q;
      chk_region_d = chk_region_q;
      chk_attr_d   = chk_attr_q;
      if (accept) begin
         chk_valid_d  = 1'b1;
         chk_hit_d    = 1'b0;
         chk_region_d = '0;
         chk_attr_d   = DefaultAttr;
         // Walk downwards so the lowest matching index is the one that sticks.
         for (int i = NrRegions - 1; i >= 0; i--) begin
            if (match[i]) begin
               chk_hit_d    = 1'b1;
               chk_region_d = 4'(i);
               chk_attr_d   = attr_q[i];
            end
         end
      end else if (chk_ready_i) begin
         chk_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q       <= RstBase;
         length_q     <= RstLength;
         attr_q       <= RstAttr;
         lock_q       <= '0;
         cfg_rvalid_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         cfg_rdata_q  <= '0;
         chk_valid_q  <= 1'b0;
         chk_hit_q    <= 1'b0;
         chk_region_q <= '0;
         chk_attr_q   <= DefaultAttr;
      end else begin
         base_q       <= base_d;
         length_q     <= length_d;
         attr_q       <= attr_d;
         lock_q       <= lock_d;
         cfg_rvalid_q <= cfg_rvalid_d;
         cfg_err_q    <= cfg_err_d;
         cfg_rdata_q  <= cfg_rdata_d;
         chk_valid_q  <= chk_valid_d;
         chk_hit_q    <= chk_hit_d;
         chk_region_q <= chk_region_d;
         chk_attr_q   <= chk_attr_d;
      end
   end

   assign cfg_gnt_o    = cfg_req_i;
   assign cfg_rvalid_o = cfg_rvalid_q;
   assign cfg_rdata_o  = cfg_rdata_q;
   assign cfg_err_o    = cfg_err_q;
   assign chk_valid_o  = chk_valid_q;
   assign chk_hit_o    = chk_hit_q;
   assign chk_region_o = chk_region_q;
   assign chk_attr_o   = chk_attr_q;

endmodule

// File: tb/tb_pma_region_checker.sv
// Self-checking bench: random and directed traffic against a behavioural table model.
module tb_pma_region_checker;

   localparam int NR = 4;
   localparam int AW = 64;
   localparam logic [2:0] DefAttr = 3'b110;
   localparam logic [NR-1:0][AW-1:0] RBase =
      {64'hFFFF_FFFF_FFFF_F000, 64'h0000_0000_0001_8000, 64'h0000_0000_0001_0000, 64'h0000_0000_8000_0000};
   localparam logic [NR-1:0][AW-1:0] RLen =
      {64'h0000_0000_0000_2000, 64'h0000_0000_0000_0100, 64'h0000_0000_0001_0000, 64'h0000_0000_4000_0000};
   localparam logic [NR-1:0][2:0] RAttr = {3'b010, 3'b100, 3'b001, 3'b011};

   typedef struct {
      logic       hit;
      logic [3:0] region;
      logic [2:0] attr;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cfg_req_i = 1'b0, cfg_we_i = 1'b0;
   logic [3:0]    cfg_idx_i = '0;
   logic [1:0]    cfg_field_i = '0;
   logic [AW-1:0] cfg_wdata_i = '0;
   logic          cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
   logic [AW-1:0] cfg_rdata_o;
   logic          chk_valid_i = 1'b0, chk_ready_o, chk_valid_o, chk_ready_i = 1'b1, chk_hit_o;
   logic [AW-1:0] chk_addr_i = '0;
   logic [3:0]    chk_region_o;
   logic [2:0]    chk_attr_o;

   int num_checks = 0;
   int num_fails  = 0;

   logic [63:0] m_base[16];
   logic [63:0] m_len[16];
   logic [2:0]  m_attr[16];
   logic        m_lock[16];
   res_t        exp_q[$];
   logic        exp_cfg_valid = 1'b0, exp_cfg_err = 1'b0;
   logic [63:0] exp_cfg_rdata = '0;
   logic        m_ready;

   pma_region_checker #(
      .NrRegions   (NR),
      .AddrWidth   (AW),
      .RstBase     (RBase),
      .RstLength   (RLen),
      .RstAttr     (RAttr),
      .DefaultAttr (DefAttr)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .cfg_req_i    (cfg_req_i),
      .cfg_we_i     (cfg_we_i),
      .cfg_idx_i    (cfg_idx_i),
      .cfg_field_i  (cfg_field_i),
      .cfg_wdata_i  (cfg_wdata_i),
      .cfg_gnt_o    (cfg_gnt_o),
      .cfg_rvalid_o (cfg_rvalid_o),
      .cfg_rdata_o  (cfg_rdata_o),
      .cfg_err_o    (cfg_err_o),
      .chk_valid_i  (chk_valid_i),
      .chk_ready_o  (chk_ready_o),
      .chk_addr_i   (chk_addr_i),
      .chk_valid_o  (chk_valid_o),
      .chk_ready_i  (chk_ready_i),
      .chk_hit_o    (chk_hit_o),
      .chk_region_o (chk_region_o),
      .chk_attr_o   (chk_attr_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_fails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_base[i] = (i < NR) ? RBase[i] : '0;
         m_len[i]  = (i < NR) ? RLen[i]  : '0;
         m_attr[i] = (i < NR) ? RAttr[i] : '0;
         m_lock[i] = 1'b0;
      end
   endtask

   // A region covers addr when addr sits at or above base and the distance into it is below length.
   function automatic res_t model_lookup(input logic [63:0] a);
      res_t r;
      r.hit = 1'b0;
      r.region = '0;
      r.attr = DefAttr;
      for (int i = 0; i < NR; i++) begin
         if (m_len[i] != 0 && a >= m_base[i] && (a - m_base[i]) < m_len[i]) begin
            r.hit = 1'b1;
            r.region = 4'(i);
            r.attr = m_attr[i];
            break;
         end
      end
      return r;
   endfunction

   // Reference model advances on each edge using the inputs that were stable before it.
   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
         exp_q.delete();
         exp_cfg_valid = 1'b0;
      end else begin
         m_ready = (exp_q.size() == 0) || chk_ready_i;
         if (exp_q.size() > 0 && chk_ready_i) void'(exp_q.pop_front());
         if (chk_valid_i && m_ready) exp_q.push_back(model_lookup(chk_addr_i));
         exp_cfg_valid = cfg_req_i;
         exp_cfg_err   = 1'b0;
         exp_cfg_rdata = '0;
         if (cfg_req_i) begin
            exp_cfg_err = (cfg_idx_i >= NR) || (cfg_field_i == 2'd3) || (cfg_we_i && m_lock[cfg_idx_i]);
            if (!exp_cfg_err && !cfg_we_i) begin
               case (cfg_field_i)
                  2'd0: exp_cfg_rdata = m_base[cfg_idx_i];
                  2'd1: exp_cfg_rdata = m_len[cfg_idx_i];
                  default: exp_cfg_rdata = {56'd0, m_lock[cfg_idx_i], 4'd0, m_attr[cfg_idx_i]};
               endcase
            end else if (!exp_cfg_err) begin
               case (cfg_field_i)
                  2'd0: m_base[cfg_idx_i] = cfg_wdata_i;
                  2'd1: m_len[cfg_idx_i] = cfg_wdata_i;
                  default: begin
                     m_attr[cfg_idx_i] = cfg_wdata_i[2:0];
                     m_lock[cfg_idx_i] = cfg_wdata_i[7];
                  end
               endcase
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rst chk_valid", chk_valid_o, 0);
         checkOutput("rst chk_hit", chk_hit_o, 0);
         checkOutput("rst chk_region", chk_region_o, 0);
         checkOutput("rst chk_attr", chk_attr_o, DefAttr);
         checkOutput("rst cfg_rvalid", cfg_rvalid_o, 0);
         checkOutput("rst cfg_rdata", cfg_rdata_o, 0);
         checkOutput("rst cfg_err", cfg_err_o, 0);
      end else begin
         checkOutput("chk_valid", chk_valid_o, exp_q.size() > 0);
         checkOutput("chk_ready", chk_ready_o, (exp_q.size() == 0) || chk_ready_i);
         checkOutput("cfg_gnt", cfg_gnt_o, cfg_req_i);
         checkOutput("cfg_rvalid", cfg_rvalid_o, exp_cfg_valid);
         if (exp_q.size() > 0) begin
            checkOutput("chk_hit", chk_hit_o, exp_q[0].hit);
            checkOutput("chk_region", chk_region_o, exp_q[0].region);
            checkOutput("chk_attr", chk_attr_o, exp_q[0].attr);
         end
         if (exp_cfg_valid) begin
            checkOutput("cfg_err", cfg_err_o, exp_cfg_err);
            checkOutput("cfg_rdata", cfg_rdata_o, exp_cfg_rdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle();
      cfg_req_i = 1'b0;
      cfg_we_i = 1'b0;
      chk_valid_i = 1'b0;
      chk_ready_i = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      go_idle();
      #1;
      checkOutput("async rst chk_valid", chk_valid_o, 0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic do_lookup(input string name, input logic [63:0] a, input logic hit,
                            input logic [3:0] region, input logic [2:0] attr);
      step();
      chk_valid_i = 1'b1;
      chk_ready_i = 1'b1;
      chk_addr_i = a;
      step();
      chk_valid_i = 1'b0;
      checkOutput({name, " valid"}, chk_valid_o, 1);
      checkOutput({name, " hit"}, chk_hit_o, hit);
      checkOutput({name, " region"}, chk_region_o, region);
      checkOutput({name, " attr"}, chk_attr_o, attr);
   endtask

   task automatic cfg_access(input logic we, input logic [3:0] idx, input logic [1:0] fld,
                             input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
      step();
      cfg_req_i = 1'b1;
      cfg_we_i = we;
      cfg_idx_i = idx;
      cfg_field_i = fld;
      cfg_wdata_i = wdata;
      step();
      cfg_req_i = 1'b0;
      checkOutput("cfg_access rvalid", cfg_rvalid_o, 1);
      rdata = cfg_rdata_o;
      err = cfg_err_o;
   endtask

   // One cycle of random traffic, addresses biased towards the edges of live regions.
   task automatic applyStimulus();
      int k;
      logic [63:0] off;
      cfg_req_i = ($urandom_range(0, 3) == 0);
      cfg_we_i = $urandom_range(0, 1);
      cfg_idx_i = 4'($urandom_range(0, 5));
      cfg_field_i = 2'($urandom_range(0, 3));
      cfg_wdata_i = {$urandom, $urandom};
      if (cfg_field_i == 2'd1) cfg_wdata_i = 64'($urandom_range(0, 'h4000));
      if (cfg_field_i == 2'd2) cfg_wdata_i[7] = ($urandom_range(0, 15) == 0);
      chk_valid_i = ($urandom_range(0, 3) != 0);
      chk_ready_i = ($urandom_range(0, 3) != 0);
      k = $urandom_range(0, NR - 1);
      off = 64'($urandom_range(0, 16)) - 64'd8;
      case ($urandom_range(0, 3))
         0: chk_addr_i = {$urandom, $urandom};
         1: chk_addr_i = m_base[k] + off;
         default: chk_addr_i = m_base[k] + m_len[k] + off;
      endcase
   endtask

   initial begin
      logic [63:0] rd;
      logic        er;
      model_reset();
      step();
      step();
      rst_n = 1'b1;
      #1;
      checkOutput("reset chk_valid", chk_valid_o, 0);
      checkOutput("reset chk_attr", chk_attr_o, DefAttr);
      checkOutput("reset cfg_rvalid", cfg_rvalid_o, 0);

      do_lookup("rst table hit", 64'h8000_1000, 1'b1, 4'd0, 3'b011);
      do_lookup("rst table miss", 64'hC000_0000, 1'b0, 4'd0, DefAttr);
      do_lookup("last byte", 64'hBFFF_FFFF, 1'b1, 4'd0, 3'b011);
      do_lookup("overlap", 64'h1_8080, 1'b1, 4'd1, 3'b001);
      do_lookup("overflow low", 64'h0, 1'b0, 4'd0, DefAttr);
      do_lookup("overflow top", 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 4'd3, 3'b010);

      // Output stalled: first result must hold while later requests wait.
      step();
      chk_valid_i = 1'b1;
      chk_ready_i = 1'b0;
      chk_addr_i = 64'h8000_0010;
      step();
      chk_addr_i = 64'h1_8080;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("stall ready", chk_ready_o, 0);
         checkOutput("stall valid", chk_valid_o, 1);
         checkOutput("stall region", chk_region_o, 0);
         checkOutput("stall attr", chk_attr_o, 3'b011);
      end
      chk_ready_i = 1'b1;
      step();
      chk_valid_i = 1'b0;
      checkOutput("release region", chk_region_o, 1);
      checkOutput("release attr", chk_attr_o, 3'b001);
      step();
      checkOutput("drained valid", chk_valid_o, 0);

      cfg_access(1'b1, 4'd3, 2'd2, 64'h81, rd, er);
      checkOutput("lock write err", er, 0);
      cfg_access(1'b1, 4'd3, 2'd0, 64'h1234, rd, er);
      checkOutput("locked base err", er, 1);
      checkOutput("locked base rdata", rd, 0);
      cfg_access(1'b0, 4'd3, 2'd0, 64'h0, rd, er);
      checkOutput("locked base readback", rd, 64'hFFFF_FFFF_FFFF_F000);
      cfg_access(1'b0, 4'd3, 2'd2, 64'h0, rd, er);
      checkOutput("attr readback", rd, 64'h81);
      step();
      chk_valid_i = 1'b1;
      chk_ready_i = 1'b0;
      chk_addr_i = 64'h8000_0000;
      step();
      checkOutput("pending before reset", chk_valid_o, 1);
      do_reset();
      cfg_access(1'b1, 4'd3, 2'd0, 64'h1234, rd, er);
      checkOutput("unlocked base err", er, 0);
      cfg_access(1'b0, 4'd3, 2'd0, 64'h0, rd, er);
      checkOutput("unlocked base readback", rd, 64'h1234);
      cfg_access(1'b0, 4'd3, 2'd2, 64'h0, rd, er);
      checkOutput("reset attr readback", rd, 64'h2);

      // Disable region0 in the same cycle a lookup into it is accepted.
      step();
      cfg_req_i = 1'b1;
      cfg_we_i = 1'b1;
      cfg_idx_i = 4'd0;
      cfg_field_i = 2'd1;
      cfg_wdata_i = 64'h0;
      chk_valid_i = 1'b1;
      chk_addr_i = 64'h8000_0000;
      step();
      cfg_req_i = 1'b0;
      checkOutput("race err", cfg_err_o, 0);
      checkOutput("race old hit", chk_hit_o, 1);
      checkOutput("race old attr", chk_attr_o, 3'b011);
      step();
      chk_valid_i = 1'b0;
      checkOutput("race new hit", chk_hit_o, 0);
      checkOutput("race new attr", chk_attr_o, DefAttr);

      cfg_access(1'b0, 4'd5, 2'd0, 64'h0, rd, er);
      checkOutput("bad idx err", er, 1);
      checkOutput("bad idx rdata", rd, 0);
      cfg_access(1'b1, 4'd1, 2'd3, 64'hFF, rd, er);
      checkOutput("rsvd field err", er, 1);

      for (int c = 0; c < 3000; c++) begin
         step();
         if (c == 1500) do_reset();
         else applyStimulus();
      end
      step();
      go_idle();
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
